// File: rtl/sdfm_fifo.sv
// Sigma-delta filter output FIFO with a one-word presentation register and an ack handshake.
// Optional threshold interrupt is built when SDFM_FIFO_IRQ_EN is defined; otherwise IRQ is tied low.
module sdfm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    input  logic             EN,
    input  logic             FLT_VALID,
    input  logic [WIDTH-1:0] FLT_DATA,
    input  logic             RD_ACK,
    input  logic             OVF_CLR,
    input  logic [AW:0]      THRESH,
    output logic [WIDTH-1:0] fifo_data,
    output logic             data_valid,
    output logic [AW:0]      LEVEL,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVF,
    output logic             IRQ
);

    typedef enum logic {IDLE, WAIT_ACK} state_e;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic             data_valid_q, data_valid_d;
    logic             ovf_q, ovf_d;
    logic             pop, push, ovf_set, full, empty;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!empty) state_d = WAIT_ACK;
            WAIT_ACK: if (RD_ACK) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        pop = (state_q == IDLE) && !empty;
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        push         = FLT_VALID & EN & (!full | pop);
        ovf_set      = FLT_VALID & EN & full & !pop;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d      = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        fifo_data_d  = pop ? mem[rd_ptr_q] : fifo_data_q;
        data_valid_d = pop;
        ovf_d        = ovf_set ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            fifo_data_q  <= '0;
            data_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            fifo_data_q  <= fifo_data_d;
            data_valid_q <= data_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge SYSCLK) begin
        if (push && !SYSRST) mem[wr_ptr_q] <= FLT_DATA;
    end

    assign fifo_data  = fifo_data_q;
    assign data_valid = data_valid_q;
    assign LEVEL      = level_q;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign OVF        = ovf_q;

`ifdef SDFM_FIFO_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = ((THRESH != '0) && (level_q >= THRESH)) || ovf_q;
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign IRQ = irq_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign IRQ = 1'b0;
`endif

endmodule
